// File: rtl/adam_rst_seq.sv
// -----------------------------------------------------------------------------
// adam_rst_seq - system reset sequencer
//
// Holds every reset domain in reset for RST_CYCLES after the global reset
// drops. It then releases the memory domains, then the DMA domains, then the
// CPU domains, with STEP_CYCLES between each release. Once all domains are
// running it raises sys_ready.
//
// A software warm reset (sw_rst_req, sampled only while running) first
// quiesces every CPU and DMA through pause_req/pause_ack. It then re-asserts
// all domain resets, loads the shadow boot address into cpu_boot_addr and
// replays the release sequence.
//
// Optional feature (macro ADAM_RST_SEQ_TIMEOUT_EN):
//   When defined, the pause handshake is abandoned after PAUSE_TIMEOUT cycles
//   and the sticky pause_timeout flag is raised. When undefined, the sequencer
//   waits for the acknowledge indefinitely and pause_timeout is always 0.
//
// Ports:
//   clk             in   system clock
//   rst             in   synchronous active-high reset
//   sw_rst_req      in   warm reset request (level, honoured only in RUN)
//   boot_addr_we    in   shadow boot address write enable
//   boot_addr_wdata in   new shadow boot address
//   mem_rst         out  memory domain resets (active high)
//   dma_rst         out  DMA domain resets (active high)
//   cpu_rst         out  CPU domain resets (active high)
//   cpu_boot_addr   out  boot address presented to all CPUs
//   pause_req       out  pause request, CPUs in the low bits, DMAs above
//   pause_ack       in   pause acknowledge, same bit order as pause_req
//   sys_ready       out  all domains released and no warm reset in progress
//   pause_timeout   out  sticky pause-timeout flag (cleared only by rst)
// -----------------------------------------------------------------------------
module adam_rst_seq #(
    parameter int                    NO_CPUS       = 1,
    parameter int                    NO_DMAS       = 1,
    parameter int                    NO_MEMS       = 3,
    parameter int                    ADDR_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR     = '0,
    parameter int                    RST_CYCLES    = 5,
    parameter int                    STEP_CYCLES   = 4,
    parameter int                    PAUSE_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sw_rst_req,
    input  logic                          boot_addr_we,
    input  logic [ADDR_WIDTH-1:0]         boot_addr_wdata,
    output logic [NO_MEMS-1:0]            mem_rst,
    output logic [NO_DMAS-1:0]            dma_rst,
    output logic [NO_CPUS-1:0]            cpu_rst,
    output logic [ADDR_WIDTH-1:0]         cpu_boot_addr,
    output logic [NO_CPUS+NO_DMAS-1:0]    pause_req,
    input  logic [NO_CPUS+NO_DMAS-1:0]    pause_ack,
    output logic                          sys_ready,
    output logic                          pause_timeout
);

    localparam int PW      = NO_CPUS + NO_DMAS;
    localparam int MAX_RS  = (RST_CYCLES > STEP_CYCLES) ? RST_CYCLES : STEP_CYCLES;
    localparam int CNT_MAX = (MAX_RS > PAUSE_TIMEOUT) ? MAX_RS : PAUSE_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Terminal counts: a phase ends on the cycle its counter shows N-1, so the
    // next phase's outputs appear exactly N cycles after the phase started.
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
`ifdef ADAM_RST_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(PAUSE_TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_REL_MEM = 3'd1,
        ST_REL_DMA = 3'd2,
        ST_REL_CPU = 3'd3,
        ST_RUN     = 3'd4,
        ST_PAUSE   = 3'd5
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [NO_MEMS-1:0]      mem_rst_r;
    logic [NO_DMAS-1:0]      dma_rst_r;
    logic [NO_CPUS-1:0]      cpu_rst_r;
    logic [ADDR_WIDTH-1:0]   boot_addr_r;
    logic [ADDR_WIDTH-1:0]   shadow_r;
    logic [PW-1:0]           pause_req_r;
    logic                    sys_ready_r;
    logic                    pause_timeout_r;

    logic                    ack_all_s;
    logic                    timeout_hit_s;
    logic                    pause_done_s;
    logic [ADDR_WIDTH-1:0]   shadow_next_s;

    // Only a simultaneous acknowledge from every CPU and DMA ends the pause.
    function automatic logic all_acked(input logic [PW-1:0] ack);
        return &ack;
    endfunction

    // Pause exit conditions and the shadow value as it will be after this edge,
    // so a write coinciding with PAUSE->HOLD is the one that gets latched.
    always_comb begin
        ack_all_s     = 1'b0;
        timeout_hit_s = 1'b0;
        pause_done_s  = 1'b0;
        shadow_next_s = shadow_r;

        ack_all_s = all_acked(pause_ack);
`ifdef ADAM_RST_SEQ_TIMEOUT_EN
        if (cnt_r == TO_LAST) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
`else
        timeout_hit_s = 1'b0;
`endif
        if ((state_r == ST_PAUSE) && (ack_all_s || timeout_hit_s)) begin
            pause_done_s = 1'b1;
        end else begin
            pause_done_s = 1'b0;
        end

        if (boot_addr_we) begin
            shadow_next_s = boot_addr_wdata;
        end else begin
            shadow_next_s = shadow_r;
        end
    end

    // Sequencer FSM with all outputs registered; every release edge is a
    // direct register load in the transition that enters the next phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_HOLD;
            cnt_r           <= '0;
            mem_rst_r       <= '1;
            dma_rst_r       <= '1;
            cpu_rst_r       <= '1;
            pause_req_r     <= '0;
            sys_ready_r     <= 1'b0;
            pause_timeout_r <= 1'b0;
            boot_addr_r     <= BOOT_ADDR;
            shadow_r        <= BOOT_ADDR;
        end else begin
            shadow_r <= shadow_next_s;

            case (state_r)
                ST_HOLD: begin
                    if (cnt_r == RST_LAST) begin
                        state_r   <= ST_REL_MEM;
                        cnt_r     <= '0;
                        mem_rst_r <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end

                ST_REL_MEM: begin
                    if (cnt_r == STEP_LAST) begin
                        state_r   <= ST_REL_DMA;
                        cnt_r     <= '0;
                        dma_rst_r <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end

                ST_REL_DMA: begin
                    if (cnt_r == STEP_LAST) begin
                        state_r   <= ST_REL_CPU;
                        cnt_r     <= '0;
                        cpu_rst_r <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end

                // CPUs were released on entry; ready follows one cycle later.
                ST_REL_CPU: begin
                    state_r     <= ST_RUN;
                    cnt_r       <= '0;
                    sys_ready_r <= 1'b1;
                end

                // Warm reset requests are honoured only here and never queued.
                ST_RUN: begin
                    if (sw_rst_req) begin
                        state_r     <= ST_PAUSE;
                        cnt_r       <= '0;
                        sys_ready_r <= 1'b0;
                        pause_req_r <= '1;
                    end else begin
                        cnt_r <= '0;
                    end
                end

                ST_PAUSE: begin
                    if (pause_done_s) begin
                        state_r     <= ST_HOLD;
                        cnt_r       <= '0;
                        mem_rst_r   <= '1;
                        dma_rst_r   <= '1;
                        cpu_rst_r   <= '1;
                        pause_req_r <= '0;
                        boot_addr_r <= shadow_next_s;
                        // An ack arriving on the timeout cycle is a clean ack.
                        if (timeout_hit_s && !ack_all_s) begin
                            pause_timeout_r <= 1'b1;
                        end else begin
                            pause_timeout_r <= pause_timeout_r;
                        end
                    end else begin
`ifdef ADAM_RST_SEQ_TIMEOUT_EN
                        cnt_r <= cnt_r + CNT_W'(1);
`else
                        cnt_r <= '0;
`endif
                    end
                end

                // Unreachable encodings fall back to a full re-sequence.
                default: begin
                    state_r     <= ST_HOLD;
                    cnt_r       <= '0;
                    mem_rst_r   <= '1;
                    dma_rst_r   <= '1;
                    cpu_rst_r   <= '1;
                    pause_req_r <= '0;
                    sys_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rst       = mem_rst_r;
    assign dma_rst       = dma_rst_r;
    assign cpu_rst       = cpu_rst_r;
    assign cpu_boot_addr = boot_addr_r;
    assign pause_req     = pause_req_r;
    assign sys_ready     = sys_ready_r;
    assign pause_timeout = pause_timeout_r;

endmodule

// File: tb/tb_adam_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_adam_rst_seq - self-checking bench for adam_rst_seq.
//
// The reference model describes the sequencer as a timeline. k is the cycle
// number since the last cold or warm restart, and every domain's reset follows
// from comparing k against the release offsets. A separate flag marks an
// outstanding pause. Directed steps cover the documented scenarios, and a
// randomized tail follows. Every output is compared on every cycle.
// -----------------------------------------------------------------------------
module tb_adam_rst_seq;

    localparam int NC  = 1;
    localparam int ND  = 1;
    localparam int NM  = 3;
    localparam int AW  = 32;
    localparam int R   = 5;
    localparam int S   = 4;
    localparam int TO  = 8;
    localparam int RUN_K = R + 2 * S + 1;
    localparam logic [AW-1:0] BOOT = 32'h0000_0000;
`ifdef ADAM_RST_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              sw_rst_req;
    logic              boot_addr_we;
    logic [AW-1:0]     boot_addr_wdata;
    logic [NM-1:0]     mem_rst;
    logic [ND-1:0]     dma_rst;
    logic [NC-1:0]     cpu_rst;
    logic [AW-1:0]     cpu_boot_addr;
    logic [NC+ND-1:0]  pause_req;
    logic [NC+ND-1:0]  pause_ack;
    logic              sys_ready;
    logic              pause_timeout;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          k;
    bit          paused;
    int          pwait;
    bit          to_m;
    logic [AW-1:0] shadow_m;
    logic [AW-1:0] boot_m;

    adam_rst_seq #(
        .NO_CPUS      (NC),
        .NO_DMAS      (ND),
        .NO_MEMS      (NM),
        .ADDR_WIDTH   (AW),
        .BOOT_ADDR    (BOOT),
        .RST_CYCLES   (R),
        .STEP_CYCLES  (S),
        .PAUSE_TIMEOUT(TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sw_rst_req     (sw_rst_req),
        .boot_addr_we   (boot_addr_we),
        .boot_addr_wdata(boot_addr_wdata),
        .mem_rst        (mem_rst),
        .dma_rst        (dma_rst),
        .cpu_rst        (cpu_rst),
        .cpu_boot_addr  (cpu_boot_addr),
        .pause_req      (pause_req),
        .pause_ack      (pause_ack),
        .sys_ready      (sys_ready),
        .pause_timeout  (pause_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (k=%0d paused=%0d)", tag, obs, exp, k, paused);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        logic [AW-1:0] sh_next;
        sh_next = boot_addr_we ? boot_addr_wdata : shadow_m;
        if (rst) begin
            k = 0; paused = 1'b0; pwait = 0; to_m = 1'b0;
            shadow_m = BOOT; boot_m = BOOT;
        end else begin
            if (paused) begin
                if (&pause_ack) begin
                    paused = 1'b0; k = 0; boot_m = sh_next;
                end else if (TO_EN && (pwait == TO - 1)) begin
                    paused = 1'b0; k = 0; boot_m = sh_next; to_m = 1'b1;
                end else begin
                    pwait++;
                end
            end else if (k >= RUN_K) begin
                if (sw_rst_req) begin
                    paused = 1'b1; pwait = 0;
                end
            end else begin
                k++;
            end
            shadow_m = sh_next;
        end
    endtask

    task automatic check_all();
        logic [NM-1:0]    e_mem;
        logic [ND-1:0]    e_dma;
        logic [NC-1:0]    e_cpu;
        logic [NC+ND-1:0] e_preq;
        e_mem  = (k < R)         ? {NM{1'b1}} : {NM{1'b0}};
        e_dma  = (k < R + S)     ? {ND{1'b1}} : {ND{1'b0}};
        e_cpu  = (k < R + 2 * S) ? {NC{1'b1}} : {NC{1'b0}};
        e_preq = paused ? {(NC+ND){1'b1}} : {(NC+ND){1'b0}};
        chk("mem_rst",       64'(mem_rst),       64'(e_mem));
        chk("dma_rst",       64'(dma_rst),       64'(e_dma));
        chk("cpu_rst",       64'(cpu_rst),       64'(e_cpu));
        chk("pause_req",     64'(pause_req),     64'(e_preq));
        chk("sys_ready",     64'(sys_ready),     64'(!paused && (k >= RUN_K)));
        chk("cpu_boot_addr", 64'(cpu_boot_addr), 64'(boot_m));
        chk("pause_timeout", 64'(pause_timeout), 64'(to_m));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; sw_rst_req = 1'b0; boot_addr_we = 1'b0;
        boot_addr_wdata = '0; pause_ack = '0;
        k = 0; paused = 1'b0; pwait = 0; to_m = 1'b0;
        shadow_m = BOOT; boot_m = BOOT;

        // Cold boot: 3 reset cycles, then the full release timeline.
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b0;
        for (int i = 0; i < 18; i++) cycle();

        // Warm reset with boot address update; CPU ack at +3, DMA ack at +6.
        boot_addr_we = 1'b1; boot_addr_wdata = 32'h8000_0000;
        cycle();
        boot_addr_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sw_rst_req   = (i == 0);
            pause_ack[0] = (i >= 3);
            pause_ack[1] = (i >= 6);
            cycle();
        end
        sw_rst_req = 1'b0; pause_ack = '0;
        for (int i = 0; i < 18; i++) cycle();

        // Request during REL_DMA only is ignored.
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < 18; i++) begin
            sw_rst_req = (k >= R + S) && (k < R + 2 * S);
            cycle();
        end
        sw_rst_req = 1'b0;

        // Hard reset at cycle 10 with DMA already released.
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < 20 && k != 10; i++) cycle();
        chk("reached_k10", 64'(k), 64'd10);
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < 18; i++) cycle();

        // Ack glitch: CPU acks twice then drops, DMA acks alone, then both.
        // The shadow write on the exit cycle must be the latched address.
        sw_rst_req = 1'b1; cycle(); sw_rst_req = 1'b0;
        pause_ack = 2'b01; cycle();
        pause_ack = 2'b01; cycle();
        pause_ack = 2'b00; cycle();
        pause_ack = 2'b10; cycle();
        boot_addr_we = 1'b1; boot_addr_wdata = 32'h1234_5678;
        pause_ack = 2'b11; cycle();
        boot_addr_we = 1'b0; pause_ack = 2'b00;
        for (int i = 0; i < 18; i++) cycle();

        // Timeout path (or, without the feature, a long unacknowledged pause).
        sw_rst_req = 1'b1; cycle(); sw_rst_req = 1'b0;
        pause_ack = 2'b01;
        for (int i = 0; i < 20; i++) cycle();
        pause_ack = 2'b11; cycle();
        pause_ack = 2'b00;
        for (int i = 0; i < 20; i++) cycle();
        // A clean warm reset afterwards leaves the sticky flag alone.
        sw_rst_req = 1'b1; cycle(); sw_rst_req = 1'b0;
        pause_ack = 2'b11; cycle();
        pause_ack = 2'b00;
        for (int i = 0; i < 18; i++) cycle();

        // Randomized traffic against the timeline model.
        for (int i = 0; i < 1500; i++) begin
            rst             = ($urandom_range(0, 249) == 0);
            sw_rst_req      = ($urandom_range(0, 15) == 0);
            boot_addr_we    = ($urandom_range(0, 7) == 0);
            boot_addr_wdata = $urandom();
            pause_ack       = 2'($urandom_range(0, 3));
            cycle();
        end

        rst = 1'b0; sw_rst_req = 1'b0; boot_addr_we = 1'b0; pause_ack = '0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adam_rst_seq.md
Name: adam_rst_seq

Overview:
- System reset sequencer; consumes the global SoC config: domain counts, reset boot address and reset stretch length.
- Stretches reset, then releases the memory, DMA and CPU reset domains in order, and presents the CPU boot address.
- Handles software warm reset: quiesces CPUs/DMAs via pause_req/pause_ack, then replays the release sequence.

Parameters:
- NO_CPUS, 1, number of CPU reset domains (>=1)
- NO_DMAS, 1, number of DMA reset domains (>=1)
- NO_MEMS, 3, number of memory reset domains (>=1)
- ADDR_WIDTH, 32, boot address width
- BOOT_ADDR, '0, boot address after hard reset
- RST_CYCLES, 5, stretch cycles before the first release (>=1)
- STEP_CYCLES, 4, cycles between successive domain releases (>=1)
- PAUSE_TIMEOUT, 64, pause wait limit; used only with the optional feature

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sw_rst_req  in  1  warm reset request, level sampled
- boot_addr_we  in  1  write enable for the shadow boot address
- boot_addr_wdata  in  ADDR_WIDTH  new shadow boot address
- mem_rst  out  NO_MEMS  memory domain resets, active high
- dma_rst  out  NO_DMAS  DMA domain resets, active high
- cpu_rst  out  NO_CPUS  CPU domain resets, active high
- cpu_boot_addr  out  ADDR_WIDTH  boot address for all CPUs
- pause_req  out  NO_CPUS+NO_DMAS  pause request; CPUs in the low bits
- pause_ack  in  NO_CPUS+NO_DMAS  pause acknowledge, same bit order
- sys_ready  out  1  high when all domains are out of reset
- pause_timeout  out  1  sticky timeout flag

Behaviour:
- One clock; synchronous active-high reset; all outputs registered.
- Reset values (rst high):
  - all *_rst outputs all-ones; pause_req 0; sys_ready 0; pause_timeout 0
  - cpu_boot_addr = BOOT_ADDR; shadow boot address = BOOT_ADDR
  - state HOLD; counter 0
- Counter width: $clog2(max(RST_CYCLES, STEP_CYCLES, PAUSE_TIMEOUT)+1).
- FSM HOLD -> REL_MEM -> REL_DMA -> REL_CPU -> RUN -> PAUSE -> HOLD. Cycle 0 = first cycle rst low or first cycle in HOLD:
  - HOLD: counts; at count RST_CYCLES-1 goes to REL_MEM; mem_rst all 0 from cycle RST_CYCLES.
  - REL_MEM: after STEP_CYCLES cycles, dma_rst all 0 from cycle RST_CYCLES+STEP_CYCLES.
  - REL_DMA: after STEP_CYCLES cycles, cpu_rst all 0 from cycle RST_CYCLES+2*STEP_CYCLES.
  - REL_CPU: one cycle; sys_ready 1 from cycle RST_CYCLES+2*STEP_CYCLES+1; enter RUN.
  - RUN: sw_rst_req high -> PAUSE next cycle; sys_ready 0 and pause_req all-ones from that cycle.
  - PAUSE: when pause_ack is all-ones in a cycle, the next cycle has:
    - all *_rst all-ones
    - pause_req 0
    - cpu_boot_addr <= shadow
    - state HOLD, counter 0
- sw_rst_req is ignored outside RUN and not queued. If it is still high on return to RUN, a new warm reset starts.
- Partial acks hold PAUSE. Acks dropping before all are high restart the wait; only simultaneous all-ones counts.
- pause_ack is ignored outside PAUSE.
- Shadow boot address:
  - boot_addr_we writes it in any state.
  - cpu_boot_addr changes only on PAUSE->HOLD and on hard reset, never while CPUs run.
  - A write in the same cycle as PAUSE->HOLD is the value latched.
- rst asserted in any state, including mid-PAUSE or mid-release, returns to reset values in the next cycle.
- Domain resets within a group always switch together. Release order is never violated.

Optional Feature:
- Macro: ADAM_RST_SEQ_TIMEOUT_EN.
- Defined:
  - PAUSE counts cycles.
  - If pause_ack is not all-ones by PAUSE_TIMEOUT cycles in PAUSE, transition to HOLD as if acked.
  - Set pause_timeout = 1; it is sticky until rst (not cleared by warm reset).
  - An all-ones ack on the timeout cycle counts as a normal ack; flag stays 0.
- Not defined: PAUSE waits indefinitely; pause_timeout tied 0; PAUSE_TIMEOUT unused.

Test Plan:
- Cold boot, defaults: rst high 3 cycles then low -> mem_rst=3'b000 at cycle 5, dma_rst=0 at 9, cpu_rst=0 at 13, sys_ready=1 at 14, cpu_boot_addr=0 throughout.
- Warm reset, boot address update:
  - In RUN, write boot_addr_wdata=32'h8000_0000, pulse sw_rst_req -> pause_req=2'b11.
  - Ack CPU at +3, DMA at +6 -> all resets high at +7, cpu_boot_addr=32'h8000_0000.
  - Release sequence replays with the same 5/9/13/14 offsets.
- Ignored request: sw_rst_req high during REL_DMA only -> no PAUSE entry; sequence completes; sys_ready=1 at 14.
- Mid-sequence hard reset: rst high at cycle 10 (dma already released) -> dma_rst=1, mem_rst=1 next cycle; full sequence restarts from rst low.
- Timeout (macro defined, PAUSE_TIMEOUT=8): warm reset with DMA ack never asserted -> resets asserted after 8 PAUSE cycles; pause_timeout=1, still 1 after the following RUN.
- Ack glitch: CPU ack high 2 cycles then low, DMA ack high later -> stays in PAUSE until both high in the same cycle.
